booth_arbiter: RTL and testbench

BOOTH_ARBITER -- requirements
Module: booth_arbiter

---
 rtl/booth_arbiter.sv | 164 ++++++++++++++++
 tb/tb_booth_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/booth_arbiter.sv
// Two-requester round-robin front end for a shared serial booth multiplier.
// A granted requester's operands are captured at grant time, then streamed
// to the multiplier (multiplicand, then multiplier). The product is collected
// from the multiplier result bus while the multiplier runs. A watchdog
// aborts a run that never signals completion.
//
// Handshake: req[i] is a level request. It is sampled only in IDLE, and
// dropping it while granted has no effect. gnt is one-hot and is held from
// the grant edge until the edge that leaves DONE. done[i] pulses for exactly
// one cycle (the DONE state) to the granted requester. err and result are
// valid with that pulse, and result holds until the next done.
module booth_arbiter #(
    parameter int BUS_WIDTH = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               req,
    input  logic [BUS_WIDTH-1:0]     opa0,
    input  logic [BUS_WIDTH-1:0]     opb0,
    input  logic [BUS_WIDTH-1:0]     opa1,
    input  logic [BUS_WIDTH-1:0]     opb1,
    output logic [1:0]               gnt,
    output logic [1:0]               done,
    output logic                     err,
    output logic [2*BUS_WIDTH-1:0]   result,
    output logic [BUS_WIDTH-1:0]     mul_inbus,
    output logic                     mul_beginsig,
    output logic                     mul_locksig,
    input  logic [BUS_WIDTH-1:0]     mul_outbus,
    input  logic                     mul_endsig,
    output logic [2:0]               fsm_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_M = 3'd1,
        LOAD_Q = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic                 prio;         // requester favoured when both request
    logic                 win;          // arbitration winner index this cycle
    logic [BUS_WIDTH-1:0] a_q;
    logic [BUS_WIDTH-1:0] b_q;
    logic [BUS_WIDTH-1:0] s1;
    logic [BUS_WIDTH-1:0] s2;
    logic [CW-1:0]        count;
    logic                 timeout_hit;

    assign fsm_state = state;

    // The last RUN cycle is the one where the counter is about to reach
    // TIMEOUT, so an aborted run lasts exactly TIMEOUT RUN cycles.
    assign timeout_hit = (count == CW'(TIMEOUT - 1));

    // Round-robin winner: a lone request wins, contention goes to prio
    always_comb begin
        win = 1'b0;
        if (req[0] && req[1]) begin
            win = prio;
        end else begin
            win = req[1];
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and per-state multiplier controls
    always_comb begin
        state_nx     = state;
        mul_beginsig = 1'b1;
        mul_locksig  = 1'b0;
        mul_inbus    = '0;
        done         = 2'b00;
        unique case (state)
            IDLE: begin
                if (|req) state_nx = LOAD_M;
            end
            LOAD_M: begin
                mul_beginsig = 1'b0;
                mul_locksig  = 1'b1;
                mul_inbus    = a_q;
                state_nx     = LOAD_Q;
            end
            LOAD_Q: begin
                mul_beginsig = 1'b0;
                mul_locksig  = 1'b1;
                mul_inbus    = b_q;
                state_nx     = RUN;
            end
            RUN: begin
                mul_beginsig = 1'b0;
                mul_locksig  = 1'b1;
                if (mul_endsig || timeout_hit) state_nx = DONE;
            end
            DONE: begin
                done     = gnt;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Grant, operand capture, watchdog, result pipe and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt    <= 2'b00;
            prio   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            s1     <= '0;
            s2     <= '0;
            count  <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        gnt <= win ? 2'b10 : 2'b01;
                        a_q <= win ? opa1 : opa0;
                        b_q <= win ? opb1 : opb0;
                    end
                end
                LOAD_Q: begin
                    count <= '0;
                end
                RUN: begin
                    if (count != CW'(TIMEOUT)) count <= count + 1'b1;
                    s1 <= mul_outbus;
                    s2 <= s1;
                    // Completion takes precedence over a coincident timeout
                    if (mul_endsig) begin
                        result <= {s2, s1};
                        err    <= 1'b0;
                    end else if (timeout_hit) begin
                        result <= '0;
                        err    <= 1'b1;
                    end
                end
                DONE: begin
                    gnt  <= 2'b00;
                    // Favour the other requester next time
                    prio <= ~gnt[1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_arbiter.sv
// Directed bench for booth_arbiter. Driver tasks issue transactions and play
// the multiplier; each issued transaction pushes its expected
// {done, err, result} onto exp_q. A separate monitor pops it whenever done
// pulses.
module tb_booth_arbiter;

    localparam int W  = 8;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req;
    logic [W-1:0]   opa0, opb0, opa1, opb1;
    logic [1:0]     gnt, done;
    logic           err;
    logic [2*W-1:0] result;
    logic [W-1:0]   mul_inbus, mul_outbus;
    logic           mul_beginsig, mul_locksig, mul_endsig;
    logic [2:0]     fsm_state;

    int checks = 0;
    int errors = 0;
    logic [18:0] exp_q[$];

    booth_arbiter #(.BUS_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req),
        .opa0(opa0), .opb0(opb0), .opa1(opa1), .opb1(opb1),
        .gnt(gnt), .done(done), .err(err), .result(result),
        .mul_inbus(mul_inbus), .mul_beginsig(mul_beginsig),
        .mul_locksig(mul_locksig), .mul_outbus(mul_outbus),
        .mul_endsig(mul_endsig), .fsm_state(fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [18:0] e;
        if (reset === 1'b0 && done !== 2'b00) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {30'd0, done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done", {30'd0, done}, {30'd0, e[18:17]});
                check("err", {31'd0, err}, {31'd0, e[16]});
                check("result", {16'd0, result}, {16'd0, e[15:0]});
                check("done_vs_gnt", {30'd0, done}, {30'd0, gnt});
            end
        end
    end

    // One transaction. The multiplier model drives hi/lo in the two RUN
    // cycles before end_cyc, and asserts endsig in RUN cycle end_cyc.
    // end_cyc = 0 means endsig is never asserted.
    task automatic txn(input logic [1:0] r, input logic [1:0] eg,
                       input logic [7:0] ea, input logic [7:0] eb,
                       input logic [7:0] hi, input logic [7:0] lo,
                       input int end_cyc, input logic [15:0] eres,
                       input logic eerr, input bit scramble, input bit keep);
        bit seen;
        bit run_ok;
        int k;
        req = r;
        exp_q.push_back({eg, eerr, eres});
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) seen = 1;
        end
        check("grant_wait", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("gnt", {30'd0, gnt}, {30'd0, eg});
            check("inbus_opa", {24'd0, mul_inbus}, {24'd0, ea});
            check("load_ctrl", {30'd0, mul_beginsig, mul_locksig}, 32'd1);
            if (scramble) begin
                opa0 = ~opa0; opb0 = ~opb0; opa1 = ~opa1; opb1 = ~opb1;
                req = 2'b00;
            end
            @(negedge clk);
            check("inbus_opb", {24'd0, mul_inbus}, {24'd0, eb});
            k = 0;
            seen = 0;
            run_ok = 1;
            while (!seen && k < TO + 8) begin
                @(negedge clk);
                k++;
                if (done != 2'b00) begin
                    seen = 1;
                end else begin
                    if (gnt !== eg || mul_inbus !== 8'h00 || {mul_beginsig, mul_locksig} !== 2'b01)
                        run_ok = 0;
                    mul_outbus = 8'hA5;
                    mul_endsig = 1'b0;
                    if (end_cyc > 0 && k == end_cyc - 2) mul_outbus = hi;
                    if (end_cyc > 0 && k == end_cyc - 1) mul_outbus = lo;
                    if (end_cyc > 0 && k == end_cyc) mul_endsig = 1'b1;
                end
            end
            check("done_wait", {31'd0, seen}, 32'd1);
            check("run_cycles", k - 1, (end_cyc > 0) ? end_cyc : TO);
            check("run_ctrl", {31'd0, run_ok}, 32'd1);
            check("done_ctrl", {22'd0, mul_beginsig, mul_locksig, mul_inbus}, {22'd0, 2'b10, 8'h00});
        end
        mul_endsig = 1'b0;
        mul_outbus = 8'h00;
        req = keep ? r : 2'b00;
    endtask

    initial begin
        bit seen;
        reset = 1'b1;
        req = 2'b00;
        opa0 = 0; opb0 = 0; opa1 = 0; opb1 = 0;
        mul_outbus = 0;
        mul_endsig = 0;
        repeat (2) @(negedge clk);
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_done", {30'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_ctrl", {22'd0, mul_beginsig, mul_locksig, mul_inbus}, {22'd0, 2'b10, 8'h00});
        check("rst_state", {29'd0, fsm_state}, 32'd0);
        reset = 1'b0;

        // contention from reset: 0, 1, 0, 1 with back-to-back requests
        opa0 = 8'd3; opb0 = 8'd5; opa1 = 8'd9; opb1 = 8'd4;
        txn(2'b11, 2'b01, 8'd3, 8'd5, 8'h00, 8'h0F, 3, 16'h000F, 1'b0, 0, 1);
        txn(2'b11, 2'b10, 8'd9, 8'd4, 8'h00, 8'h24, 3, 16'h0024, 1'b0, 0, 1);
        txn(2'b11, 2'b01, 8'd3, 8'd5, 8'h00, 8'h0F, 3, 16'h000F, 1'b0, 0, 1);
        txn(2'b11, 2'b10, 8'd9, 8'd4, 8'h00, 8'h24, 3, 16'h0024, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        check("result_held", {16'd0, result}, 32'h0024);
        check("idle_gnt", {30'd0, gnt}, 32'd0);

        // 3*5 with operand changes and req drop after grant
        opa0 = 8'd3; opb0 = 8'd5;
        txn(2'b01, 2'b01, 8'd3, 8'd5, 8'h00, 8'h0F, 3, 16'h000F, 1'b0, 1, 0);

        // -2 * 7
        opa0 = 8'hFE; opb0 = 8'h07;
        txn(2'b01, 2'b01, 8'hFE, 8'h07, 8'hFF, 8'hF2, 3, 16'hFFF2, 1'b0, 0, 0);

        // watchdog abort
        opa1 = 8'h11; opb1 = 8'h22;
        txn(2'b10, 2'b10, 8'h11, 8'h22, 8'h00, 8'h00, 0, 16'h0000, 1'b1, 0, 0);

        // endsig on the last allowed RUN cycle wins over the timeout
        txn(2'b01, 2'b01, 8'hFE, 8'h07, 8'h12, 8'h34, TO, 16'h1234, 1'b0, 0, 0);

        // reset in the middle of RUN
        req = 2'b01;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) seen = 1;
        end
        check("rst_mid_grant", {31'd0, seen}, 32'd1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_gnt", {30'd0, gnt}, 32'd0);
        check("mid_rst_done", {30'd0, done}, 32'd0);
        check("mid_rst_result", {16'd0, result}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        check("mid_rst_ctrl", {22'd0, mul_beginsig, mul_locksig, mul_inbus}, {22'd0, 2'b10, 8'h00});
        check("mid_rst_state", {29'd0, fsm_state}, 32'd0);
        req = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        opa1 = 8'd6; opb1 = 8'd7;
        txn(2'b10, 2'b10, 8'd6, 8'd7, 8'h00, 8'h2A, 3, 16'h002A, 1'b0, 0, 0);

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
